// File: rtl/phase_step_meter.sv
// phase_step_meter: gated-window mean increment of a wrapping count; PHASE_STEP_METER_CONT_EN selects continuous windows
module phase_step_meter #(
  parameter int HW        = 12,
  parameter int GATE_LOG2 = 4,
  parameter int ACCW      = HW + GATE_LOG2
) (
  input  logic                 C,
  input  logic                 rst,
  input  logic [HW-1:0]        h,
  input  logic                 start,
  input  logic                 ready,
  output logic                 busy,
  output logic                 valid,
  output logic [HW-1:0]        step_int,
  output logic [GATE_LOG2-1:0] step_frac
);
  typedef enum logic [1:0] {IDLE, ARM, GATHER, DONE} state_t;
`ifdef PHASE_STEP_METER_CONT_EN
  localparam state_t AFTER_DONE = GATHER;
`else
  localparam state_t AFTER_DONE = IDLE;
`endif
  state_t               r_state, w_next;
  logic [ACCW-1:0]      r_acc, r_result, w_sum;
  logic [GATE_LOG2-1:0] r_cnt;
  logic [HW-1:0]        r_h_prev, w_delta;
  logic                 w_last, w_accept;
  assign w_delta   = h - r_h_prev;
  assign w_sum     = r_acc + ACCW'(w_delta);
  assign w_last    = r_cnt == {GATE_LOG2{1'b1}};
  assign w_accept  = r_state == DONE && ready;
  assign busy      = r_state != IDLE;
  assign valid     = r_state == DONE;
  assign step_int  = r_result[ACCW-1:GATE_LOG2];
  assign step_frac = r_result[GATE_LOG2-1:0];
  // state register
  always_ff @(posedge C)
    r_state <= rst ? IDLE : w_next;
  // next state
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE   ? (start ? ARM : IDLE) :
             r_state == ARM    ? GATHER :
             r_state == GATHER ? (w_last ? DONE : GATHER) :
                                 (ready ? AFTER_DONE : DONE);
  end
  // window accumulation; h_prev survives the handshake so back-to-back windows lose no increment
  always_ff @(posedge C) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_h_prev <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ARM) begin
        r_h_prev <= h;
        r_acc    <= '0;
        r_cnt    <= '0;
      end
      if (r_state == GATHER) begin
        r_h_prev <= h;
        r_acc    <= w_sum;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) r_result <= w_sum;
      end
      if (w_accept) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
    end
  end
endmodule
